// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the two FAM lanes of the dual-issue core.
// On a same-cycle conflict the older lane goes first and the pipe stalls one cycle while the younger lane is served.
module dm_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              l0_req,
    input  logic              l0_we,
    input  logic [3:0]        l0_wea,
    input  logic [ADDR_W-1:0] l0_addr,
    input  logic [DATA_W-1:0] l0_wdata,
    input  logic              l0_num,
    output logic [DATA_W-1:0] l0_rdata,

    input  logic              l1_req,
    input  logic              l1_we,
    input  logic [3:0]        l1_wea,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [DATA_W-1:0] l1_wdata,
    input  logic              l1_num,
    output logic [DATA_W-1:0] l1_rdata,

    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wea,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,

    output logic              stop,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] hold_rdata_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg;
    logic [3:0]        lat_wea_reg;
    logic              lat_we_reg;
    logic              lat_sel_reg;
    logic [CNT_W-1:0]  conflict_cnt_reg;

    // Per-lane views so lane selection is a simple index.
    logic [1:0]        lane_req;
    logic [1:0]        lane_we;
    logic [3:0]        lane_wea   [2];
    logic [ADDR_W-1:0] lane_addr  [2];
    logic [DATA_W-1:0] lane_wdata [2];
    logic [DATA_W-1:0] lane_rdata [2];

    assign lane_req      = {l1_req, l0_req};
    assign lane_we       = {l1_we, l0_we};
    assign lane_wea[0]   = l0_wea;
    assign lane_wea[1]   = l1_wea;
    assign lane_addr[0]  = l0_addr;
    assign lane_addr[1]  = l1_addr;
    assign lane_wdata[0] = l0_wdata;
    assign lane_wdata[1] = l1_wdata;

    logic conflict;
    logic older_id;
    logic younger_id;
    logic serve_id;

    // Tags differing means the lane tagged 0 is older; equal tags default to lane 0.
    assign older_id   = (l0_num != l1_num) & l0_num;
    assign younger_id = ~older_id;
    assign conflict   = lane_req[0] & lane_req[1];
    assign serve_id   = conflict ? older_id : (lane_req[1] & ~lane_req[0]);

    always_comb begin
        state_next = state_reg;
        dm_addr    = '0;
        dm_wea     = '0;
        dm_wdata   = '0;
        stop       = 1'b0;
        if (rst) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    dm_addr  = lane_addr[serve_id];
                    dm_wdata = lane_wdata[serve_id];
                    if (lane_req[serve_id] && lane_we[serve_id]) begin
                        dm_wea = lane_wea[serve_id];
                    end
                    if (conflict) begin
                        stop       = 1'b1;
                        state_next = SECOND;
                    end
                end
                SECOND: begin
                    dm_addr    = lat_addr_reg;
                    dm_wdata   = lat_wdata_reg;
                    dm_wea     = lat_we_reg ? lat_wea_reg : 4'b0000;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // In SECOND the lane that is not being served gets the data captured during the stall.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane_rdata
        localparam logic LANE_ID = 1'(gi);
        always_comb begin
            lane_rdata[gi] = dm_rdata;
            if (rst) begin
                lane_rdata[gi] = '0;
            end else if (state_reg == SECOND && lat_sel_reg != LANE_ID) begin
                lane_rdata[gi] = hold_rdata_reg;
            end
        end
    end

    assign l0_rdata     = lane_rdata[0];
    assign l1_rdata     = lane_rdata[1];
    assign conflict_cnt = conflict_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            hold_rdata_reg   <= '0;
            lat_addr_reg     <= '0;
            lat_wdata_reg    <= '0;
            lat_wea_reg      <= '0;
            lat_we_reg       <= 1'b0;
            lat_sel_reg      <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && conflict) begin
                hold_rdata_reg   <= dm_rdata;
                lat_addr_reg     <= lane_addr[younger_id];
                lat_wdata_reg    <= lane_wdata[younger_id];
                lat_wea_reg      <= lane_wea[younger_id];
                lat_we_reg       <= lane_we[younger_id];
                lat_sel_reg      <= younger_id;
                conflict_cnt_reg <= conflict_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a word memory hangs off the dm port and a program-order
// memory model predicts every served address, write enable, read value and stall.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        l0_req, l0_we, l0_num, l1_req, l1_we, l1_num;
    logic [3:0]  l0_wea, l1_wea, dm_wea;
    logic [31:0] l0_addr, l0_wdata, l0_rdata, l1_addr, l1_wdata, l1_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, conflict_cnt;
    logic        stop;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DATA_W(32), .ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .l0_req(l0_req), .l0_we(l0_we), .l0_wea(l0_wea), .l0_addr(l0_addr),
        .l0_wdata(l0_wdata), .l0_num(l0_num), .l0_rdata(l0_rdata),
        .l1_req(l1_req), .l1_we(l1_we), .l1_wea(l1_wea), .l1_addr(l1_addr),
        .l1_wdata(l1_wdata), .l1_num(l1_num), .l1_rdata(l1_rdata),
        .dm_addr(dm_addr), .dm_wea(dm_wea), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .stop(stop), .conflict_cnt(conflict_cnt)
    );

    // Physical memory seen by the DUT; combinational read, byte-enabled write on posedge.
    logic [31:0] phys_mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign dm_rdata = phys_mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            phys_mem[pre_idx] <= pre_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (dm_wea[b]) phys_mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
            end
        end
    end

    // Reference memory updated in program order.
    logic [31:0] ref_mem [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        pre_idx  = 6'(idx);
        pre_data = val;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic model_access(input logic we, input logic [3:0] wea, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] pre);
        pre = ref_mem[addr[7:2]];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wea[b]) ref_mem[addr[7:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] lane_rd(input int lane);
        return (lane == 0) ? l0_rdata : l1_rdata;
    endfunction

    task automatic scramble_inputs();
        l0_req = 1'($urandom_range(0, 1)); l0_we = 1'($urandom_range(0, 1));
        l0_wea = 4'($urandom); l0_addr = $urandom; l0_wdata = $urandom; l0_num = 1'($urandom_range(0, 1));
        l1_req = 1'($urandom_range(0, 1)); l1_we = 1'($urandom_range(0, 1));
        l1_wea = 4'($urandom); l1_addr = $urandom; l1_wdata = $urandom; l1_num = 1'($urandom_range(0, 1));
    endtask

    // Entered just after a posedge; returns just after the posedge that ends the pair.
    task automatic run_pair(input string tag,
                            input logic r0, input logic we0, input logic [3:0] wea0,
                            input logic [31:0] a0, input logic [31:0] d0, input logic n0,
                            input logic r1, input logic we1, input logic [3:0] wea1,
                            input logic [31:0] a1, input logic [31:0] d1, input logic n1);
        logic        r [2];
        logic        we [2];
        logic [3:0]  wea [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [31:0] v_old, v_young;
        int o, y, s;
        r[0] = r0; we[0] = we0; wea[0] = wea0; a[0] = a0; d[0] = d0;
        r[1] = r1; we[1] = we1; wea[1] = wea1; a[1] = a1; d[1] = d1;
        l0_req = r0; l0_we = we0; l0_wea = wea0; l0_addr = a0; l0_wdata = d0; l0_num = n0;
        l1_req = r1; l1_we = we1; l1_wea = wea1; l1_addr = a1; l1_wdata = d1; l1_num = n1;
        @(negedge clk);
        if (r0 && r1) begin
            o = (n0 != n1 && n0) ? 1 : 0;
            y = 1 - o;
            check({tag, " c1 stop"}, 64'(stop), 64'(1));
            check({tag, " c1 dm_addr"}, 64'(dm_addr), 64'(a[o]));
            check({tag, " c1 dm_wea"}, 64'(dm_wea), 64'(we[o] ? wea[o] : 4'b0000));
            check({tag, " c1 dm_wdata"}, 64'(dm_wdata), 64'(d[o]));
            model_access(we[o], wea[o], a[o], d[o], v_old);
            exp_cnt++;
            @(posedge clk);
            #1;
            scramble_inputs();
            @(negedge clk);
            model_access(we[y], wea[y], a[y], d[y], v_young);
            check({tag, " c2 stop"}, 64'(stop), 64'(0));
            check({tag, " c2 dm_addr"}, 64'(dm_addr), 64'(a[y]));
            check({tag, " c2 dm_wea"}, 64'(dm_wea), 64'(we[y] ? wea[y] : 4'b0000));
            check({tag, " c2 dm_wdata"}, 64'(dm_wdata), 64'(d[y]));
            check({tag, " c2 older rdata"}, 64'(lane_rd(o)), 64'(v_old));
            check({tag, " c2 younger rdata"}, 64'(lane_rd(y)), 64'(v_young));
            check({tag, " c2 conflict_cnt"}, 64'(conflict_cnt), 64'(exp_cnt));
            $display("pair %s: conflict older=l%0d addr=%h younger=l%0d addr=%h cnt=%0d",
                     tag, o, a[o], y, a[y], exp_cnt);
        end else begin
            s = (r1 && !r0) ? 1 : 0;
            check({tag, " stop"}, 64'(stop), 64'(0));
            check({tag, " dm_addr"}, 64'(dm_addr), 64'(a[s]));
            check({tag, " dm_wea"}, 64'(dm_wea), 64'((r[s] && we[s]) ? wea[s] : 4'b0000));
            check({tag, " dm_wdata"}, 64'(dm_wdata), 64'(d[s]));
            if (r[s]) begin
                model_access(we[s], wea[s], a[s], d[s], v_old);
                check({tag, " l0_rdata"}, 64'(l0_rdata), 64'(v_old));
                check({tag, " l1_rdata"}, 64'(l1_rdata), 64'(v_old));
            end
            check({tag, " conflict_cnt"}, 64'(conflict_cnt), 64'(exp_cnt));
            $display("pair %s: single req=%b%b served=l%0d addr=%h", tag, r1, r0, s, a[s]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        l0_req = 1'b1; l0_we = 1'b1; l0_wea = 4'hF; l0_addr = 32'h8; l0_wdata = 32'h1234; l0_num = 1'b0;
        l1_req = 1'b1; l1_we = 1'b1; l1_wea = 4'hF; l1_addr = 32'hC; l1_wdata = 32'h5678; l1_num = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, 32'h0101_0101 * i ^ 32'hA5A5_5A5A);

        // Reset state with both lanes requesting stores.
        @(negedge clk);
        check("rst stop", 64'(stop), 64'(0));
        check("rst dm_wea", 64'(dm_wea), 64'(0));
        check("rst dm_addr", 64'(dm_addr), 64'(0));
        check("rst dm_wdata", 64'(dm_wdata), 64'(0));
        check("rst l0_rdata", 64'(l0_rdata), 64'(0));
        check("rst l1_rdata", 64'(l1_rdata), 64'(0));
        check("rst conflict_cnt", 64'(conflict_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        l0_req = 1'b0; l1_req = 1'b0;

        preload(32'h10 >> 2, 32'hDEADBEEF);
        preload(32'h20 >> 2, 32'h11);
        preload(32'h24 >> 2, 32'h22);
        preload(32'h50 >> 2, 32'h0);

        run_pair("t1 single load", 1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        run_pair("t2 l1 older", 1, 0, 4'h0, 32'h24, 32'h0, 1, 1, 0, 4'h0, 32'h20, 32'h0, 0);
        run_pair("t3 store-load", 1, 1, 4'hF, 32'h40, 32'hCAFEF00D, 0, 1, 0, 4'h0, 32'h40, 32'h0, 1);
        run_pair("t4 load-bytestore", 1, 0, 4'h0, 32'h50, 32'h0, 0, 1, 1, 4'b0100, 32'h50, 32'h77665544, 0);
        run_pair("t5 b2b a", 1, 0, 4'h0, 32'h00, 32'h0, 0, 1, 0, 4'h0, 32'h04, 32'h0, 1);
        run_pair("t5 b2b b", 1, 1, 4'h3, 32'h08, 32'hAABBCCDD, 1, 1, 0, 4'h0, 32'h08, 32'h0, 0);
        run_pair("t5 b2b c", 1, 0, 4'h0, 32'h0C, 32'h0, 1, 1, 0, 4'h0, 32'h10, 32'h0, 1);
        run_pair("t5 idle", 0, 0, 4'hF, 32'h1C, 32'h99, 0, 0, 1, 4'hF, 32'h18, 32'h0, 0);

        // Reset in SECOND drops the younger store and clears the counter.
        l0_req = 1'b1; l0_we = 1'b0; l0_wea = 4'h0; l0_addr = 32'h60; l0_wdata = 32'h0; l0_num = 1'b0;
        l1_req = 1'b1; l1_we = 1'b1; l1_wea = 4'hF; l1_addr = 32'h64; l1_wdata = 32'h12345678; l1_num = 1'b1;
        @(negedge clk);
        check("t6 c1 stop", 64'(stop), 64'(1));
        check("t6 c1 dm_addr", 64'(dm_addr), 64'(32'h60));
        model_access(1'b0, 4'h0, 32'h60, 32'h0, v);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst dm_wea", 64'(dm_wea), 64'(0));
        check("t6 rst stop", 64'(stop), 64'(0));
        check("t6 rst dm_addr", 64'(dm_addr), 64'(0));
        check("t6 rst l1_rdata", 64'(l1_rdata), 64'(0));
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("pair t6: reset during SECOND");
        run_pair("t6 after rst", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h64, 32'h0, 1);

        for (int k = 0; k < 300; k++) begin
            run_pair($sformatf("rnd%0d", k),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                     32'($urandom_range(0, 15)) << 2, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                     32'($urandom_range(0, 15)) << 2, $urandom, 1'($urandom_range(0, 1)));
        end

        l0_req = 1'b0; l1_req = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), 64'(phys_mem[i]), 64'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
